// File: rtl/ff_seq_ctrl.sv
// Command sequencer for the JK/SR/D/T flop bank: drives one flop for N edges,
// then snapshots all four flop outputs and returns them on a response channel.
module ff_seq_ctrl #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_sel_i,
  input  logic [1:0]       cmd_val_i,
  input  logic [CNT_W-1:0] cmd_cycles_i,
  input  logic             cmd_clr_i,
  output logic             j_o,
  output logic             k_o,
  output logic             s_o,
  output logic             r_o,
  output logic             d_o,
  output logic             t_o,
  output logic             ff_rst_o,
  input  logic             qjk_i,
  input  logic             qsr_i,
  input  logic             qd_i,
  input  logic             qt_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [3:0]       rsp_q_o,
  output logic [1:0]       rsp_sel_o,
  output logic             rsp_err_o
);

  typedef enum logic [1:0] {StIdle, StDrive, StCapture, StResp} state_e;

  localparam logic [1:0] SelJk = 2'd0;
  localparam logic [1:0] SelSr = 2'd1;
  localparam logic [1:0] SelD  = 2'd2;
  localparam logic [1:0] SelT  = 2'd3;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sel_q;
  logic [1:0]       val_q;
  logic             clr_q;
  logic [3:0]       rsp_q_q;
  logic [1:0]       rsp_sel_q;
  logic             rsp_err_q;

  logic sr_illegal;
  logic drive_en;

  assign sr_illegal = !clr_q && (sel_q == SelSr) && (val_q == 2'b11);
  assign drive_en   = (state_q == StDrive) && !clr_q && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sel_q     <= '0;
      val_q     <= '0;
      clr_q     <= 1'b0;
      rsp_q_q   <= '0;
      rsp_sel_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            sel_q   <= cmd_sel_i;
            val_q   <= cmd_val_i;
            clr_q   <= cmd_clr_i;
            // A zero edge count behaves as a single edge.
            cnt_q   <= (cmd_cycles_i == '0) ? CNT_W'(1) : cmd_cycles_i;
            state_q <= StDrive;
          end
        end
        StDrive: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= StCapture;
        end
        StCapture: begin
          rsp_q_q   <= {qt_i, qd_i, qsr_i, qjk_i};
          rsp_sel_q <= sel_q;
          rsp_err_q <= sr_illegal;
          state_q   <= StResp;
        end
        StResp: begin
          if (rsp_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Unselected flops get idle drive; D is fed back so it holds its value.
  always_comb begin
    j_o = 1'b0;
    k_o = 1'b0;
    s_o = 1'b0;
    r_o = 1'b0;
    t_o = 1'b0;
    d_o = rst_i ? 1'b0 : qd_i;
    if (drive_en) begin
      unique case (sel_q)
        SelJk: begin
          j_o = val_q[1];
          k_o = val_q[0];
        end
        SelSr: begin
          if (!sr_illegal) begin
            s_o = val_q[1];
            r_o = val_q[0];
          end
        end
        SelD: d_o = val_q[0];
        SelT: t_o = val_q[0];
        default: ;
      endcase
    end
  end

  assign ff_rst_o    = rst_i || ((state_q == StDrive) && clr_q);
  assign cmd_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_q_o     = rsp_q_q;
  assign rsp_sel_o   = rsp_sel_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_ff_seq_ctrl.sv
// Bench for ff_seq_ctrl: behavioural flop bank plus a table of directed commands
// and hand-written stall / mid-command reset sequences.
module tb_ff_seq_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_sel;
  logic [1:0]       cmd_val;
  logic [CNT_W-1:0] cmd_cycles;
  logic             cmd_clr;
  logic             j, k, s, r, d, t, ff_rst;
  logic             qjk, qsr, qd, qt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_q;
  logic [1:0]       rsp_sel;
  logic             rsp_err;

  int checks = 0;
  int errors = 0;
  int sr_cnt, fr_cnt;

  always #5 clk = ~clk;

  ff_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_sel_i    (cmd_sel),
    .cmd_val_i    (cmd_val),
    .cmd_cycles_i (cmd_cycles),
    .cmd_clr_i    (cmd_clr),
    .j_o          (j),
    .k_o          (k),
    .s_o          (s),
    .r_o          (r),
    .d_o          (d),
    .t_o          (t),
    .ff_rst_o     (ff_rst),
    .qjk_i        (qjk),
    .qsr_i        (qsr),
    .qd_i         (qd),
    .qt_i         (qt),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_q_o      (rsp_q),
    .rsp_sel_o    (rsp_sel),
    .rsp_err_o    (rsp_err)
  );

  // Flop bank model
  always_ff @(posedge clk) begin
    if (ff_rst) begin
      qjk <= 1'b0;
      qsr <= 1'b0;
      qd  <= 1'b0;
      qt  <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   qjk <= 1'b0;
        2'b10:   qjk <= 1'b1;
        2'b11:   qjk <= ~qjk;
        default: qjk <= qjk;
      endcase
      if (s && !r) qsr <= 1'b1;
      else if (r && !s) qsr <= 1'b0;
      qd <= d;
      if (t) qt <= ~qt;
    end
  end

  always @(negedge clk) begin
    if (s || r) sr_cnt++;
    if (ff_rst) fr_cnt++;
  end

  typedef struct {
    logic [1:0] sel;
    logic [1:0] val;
    int         cyc;
    logic       clr;
    logic [3:0] exp_q;
    logic [1:0] exp_sel;
    logic       exp_err;
    int         exp_lat;
    int         exp_sr;
    int         exp_fr;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for rsp_valid after an accept edge; returns edges counted (bounded).
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!rsp_valid && lat < 40);
  endtask

  task automatic run_cmd(input int idx, input vec_t v);
    int lat;
    sr_cnt     = 0;
    fr_cnt     = 0;
    cmd_sel    = v.sel;
    cmd_val    = v.val;
    cmd_cycles = CNT_W'(v.cyc);
    cmd_clr    = v.clr;
    cmd_valid  = 1'b1;
    check("ready_before", idx, 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("ready_busy", idx, 32'(cmd_ready), 32'd0);
    wait_rsp(lat);
    check("latency", idx, 32'(lat), 32'(v.exp_lat));
    check("rsp_q", idx, 32'(rsp_q), 32'(v.exp_q));
    check("rsp_sel", idx, 32'(rsp_sel), 32'(v.exp_sel));
    check("rsp_err", idx, 32'(rsp_err), 32'(v.exp_err));
    check("sr_cycles", idx, 32'(sr_cnt), 32'(v.exp_sr));
    check("ffrst_cycles", idx, 32'(fr_cnt), 32'(v.exp_fr));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("ready_after", idx, 32'(cmd_ready), 32'd1);
    check("valid_after", idx, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int  lat;
    logic seen;
    //         sel    val    cyc clr  exp_q    sel    err lat sr fr
    vecs[0]  = '{2'd0, 2'b11, 3,  0, 4'b0001, 2'd0, 0,  4,  0, 0};
    vecs[1]  = '{2'd2, 2'b01, 1,  0, 4'b0101, 2'd2, 0,  2,  0, 0};
    vecs[2]  = '{2'd1, 2'b10, 2,  0, 4'b0111, 2'd1, 0,  3,  2, 0};
    vecs[3]  = '{2'd1, 2'b11, 2,  0, 4'b0111, 2'd1, 1,  3,  0, 0};
    vecs[4]  = '{2'd3, 2'b01, 0,  0, 4'b1111, 2'd3, 0,  2,  0, 0};
    vecs[5]  = '{2'd2, 2'b01, 2,  1, 4'b0000, 2'd2, 0,  3,  0, 2};
    vecs[6]  = '{2'd0, 2'b10, 15, 0, 4'b0001, 2'd0, 0,  16, 0, 0};
    vecs[7]  = '{2'd2, 2'b01, 0,  0, 4'b0101, 2'd2, 0,  2,  0, 0};
    vecs[8]  = '{2'd0, 2'b01, 2,  0, 4'b0100, 2'd0, 0,  3,  0, 0};
    vecs[9]  = '{2'd3, 2'b00, 1,  0, 4'b0100, 2'd3, 0,  2,  0, 0};
    vecs[10] = '{2'd1, 2'b10, 1,  0, 4'b0110, 2'd1, 0,  2,  1, 0};
    vecs[11] = '{2'd1, 2'b01, 3,  0, 4'b0100, 2'd1, 0,  4,  3, 0};
    vecs[12] = '{2'd2, 2'b01, 1,  0, 4'b0100, 2'd2, 0,  2,  0, 0};

    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_sel    = '0;
    cmd_val    = '0;
    cmd_cycles = '0;
    cmd_clr    = 1'b0;
    rsp_ready  = 1'b0;
    tick();
    tick();
    check("rst_cmd_ready", 0, 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 0, 32'(rsp_valid), 32'd0);
    check("rst_rsp_q", 0, 32'(rsp_q), 32'd0);
    check("rst_rsp_sel", 0, 32'(rsp_sel), 32'd0);
    check("rst_rsp_err", 0, 32'(rsp_err), 32'd0);
    check("rst_ff_rst", 0, 32'(ff_rst), 32'd1);
    check("rst_drive", 0, 32'({j, k, s, r, t, d}), 32'd0);
    rst = 1'b0;
    tick();
    check("ff_rst_released", 0, 32'(ff_rst), 32'd0);

    for (int i = 0; i < 12; i++) run_cmd(i, vecs[i]);

    // Response stall: bank is {qt,qd,qsr,qjk}=0100; JK toggle gives 0101.
    cmd_sel = 2'd0; cmd_val = 2'b11; cmd_cycles = 4'd1; cmd_clr = 1'b0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wait_rsp(lat);
    check("stall_lat", 0, 32'(lat), 32'd2);
    check("stall_q", 0, 32'(rsp_q), 32'b0101);
    cmd_sel = 2'd3; cmd_val = 2'b01; cmd_cycles = 4'd1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_hold", i, 32'({rsp_valid, cmd_ready, rsp_q}), 32'b10_0101);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("stall_release_ready", 0, 32'(cmd_ready), 32'd1);
    tick();
    check("stall_next_accepted", 0, 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    wait_rsp(lat);
    check("stall_next_lat", 0, 32'(lat), 32'd2);
    check("stall_next_q", 0, 32'(rsp_q), 32'b1101);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset during the 2nd DRIVE cycle of a long JK command.
    cmd_sel = 2'd0; cmd_val = 2'b11; cmd_cycles = 4'd5;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", 0, 32'(cmd_ready), 32'd1);
    check("midrst_valid", 0, 32'(rsp_valid), 32'd0);
    check("midrst_bank", 0, 32'({qt, qd, qsr, qjk}), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    check("midrst_no_rsp", 0, 32'(seen), 32'd0);

    run_cmd(12, vecs[12]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
